uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that moves requester bytes into a UART transmit FIFO.
// It also contains an independent FIFO-to-transmitter load pacer.
// Optional: define UART_TX_ARB_PRIO0_EN to give requester 0 fixed priority over the ring.

module uart_tx_arb #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_we,
    output logic [WIDTH-1:0]      fifo_wdata,
    input  logic                  tr_bz,
    output logic                  tr_data_load,
    output logic [2:0]            owner,
    output logic                  owner_vld
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 sits outside the ring, so the ring search starts at index 1.
    localparam int RR_LOW = 1;
`else
    localparam int RR_LOW = 0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   lastOwner_q, lastOwner_d;
    logic            ownerVld_q, ownerVld_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cntInc;
    logic            loadWait_q, loadWait_d;
    logic            load_q, load_d;

    logic            winFound;
    logic [IW-1:0]   winIdx;
    logic            selReq;
    logic            selLast;
    logic [WIDTH-1:0] selData;

    // Two-pass round-robin search: first indices above lastOwner, then wrap to the rest.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
`ifdef UART_TX_ARB_PRIO0_EN
        if (req[0]) begin
            winFound = 1'b1;
            winIdx   = '0;
        end
`endif
        for (int i = RR_LOW; i < NREQ; i++) begin
            if (!winFound && req[i] && (i > int'(lastOwner_q))) begin
                winFound = 1'b1;
                winIdx   = IW'(i);
            end
        end
        for (int i = RR_LOW; i < NREQ; i++) begin
            if (!winFound && req[i] && (i <= int'(lastOwner_q))) begin
                winFound = 1'b1;
                winIdx   = IW'(i);
            end
        end
    end

    always_comb begin
        selReq  = 1'b0;
        selLast = 1'b0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                selReq  = req[i];
                selLast = req_last[i];
                selData = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign cntInc = cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        ownerVld_d  = ownerVld_q;
        cnt_d       = cnt_q;
        fifo_we     = 1'b0;
        fifo_wdata  = '0;
        ack         = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (winFound) begin
                    owner_d    = winIdx;
                    ownerVld_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                fifo_we    = selReq & ~fifo_full;
                fifo_wdata = selData;
                for (int i = 0; i < NREQ; i++) begin
                    ack[i] = fifo_we && (owner_q == IW'(i));
                end
                // A stalled byte (fifo_full) keeps the grant; only an idle requester gives it up.
                if ((fifo_we && (selLast || (cntInc == CW'(MAX_BURST)))) || !selReq) begin
                    state_d    = ARB;
                    ownerVld_d = 1'b0;
`ifdef UART_TX_ARB_PRIO0_EN
                    lastOwner_d = (owner_q == '0) ? lastOwner_q : owner_q;
`else
                    lastOwner_d = owner_q;
`endif
                end
                if (fifo_we) begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load pacer: one pop per transmitted frame, re-armed once the transmitter reports busy.
    always_comb begin
        load_d     = ~fifo_empty & ~tr_bz & ~loadWait_q;
        loadWait_d = loadWait_q;
        if (tr_bz) begin
            loadWait_d = 1'b0;
        end else if (load_d) begin
            loadWait_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= IW'(NREQ - 1);
            ownerVld_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            ownerVld_q  <= ownerVld_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loadWait_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            loadWait_q <= loadWait_d;
            load_q     <= load_d;
        end
    end

    assign owner        = 3'(owner_q);
    assign owner_vld    = ownerVld_q;
    assign tr_data_load = load_q;

endmodule
